// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block and streams W0..W(ROUNDS-1) through a 16-word sliding window.
// Optional abort input when SHA256_SCHED_ABORT_EN is defined.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_index,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_e;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] add4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return a + b + c + d;
    endfunction

    state_e      state_q;
    logic [31:0] win_q [16];
    logic [3:0]  cnt_q;
    logic [5:0]  t_q;
    logic        load_ready_q;
    logic        w_valid_q;
    logic        done_q;

    logic        load_fire;
    logic        emit_fire;
    logic        abort_act;
    logic [31:0] next_word_d;

`ifdef SHA256_SCHED_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign load_fire = load_valid & load_ready_q;
    assign emit_fire = w_valid_q & w_ready;

    // W_{t+16} from the current window, where win_q[i] holds W_{t+i}
    always_comb begin
        next_word_d = add4(sigma1(win_q[14]), win_q[9], sigma0(win_q[1]), win_q[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            t_q          <= '0;
            load_ready_q <= 1'b1;
            w_valid_q    <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                // Any handshake coinciding with abort is dropped
                state_q      <= S_IDLE;
                cnt_q        <= '0;
                t_q          <= '0;
                load_ready_q <= 1'b1;
                w_valid_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (load_fire) begin
                            win_q[cnt_q] <= load_word;
                            cnt_q        <= cnt_q + 4'd1;
                            if (cnt_q == 4'd15) begin
                                state_q      <= S_EMIT;
                                t_q          <= '0;
                                load_ready_q <= 1'b0;
                                w_valid_q    <= 1'b1;
                            end
                        end
                    end
                    S_EMIT: begin
                        if (emit_fire) begin
                            for (int i = 0; i < 15; i++) begin
                                win_q[i] <= win_q[i+1];
                            end
                            win_q[15] <= next_word_d;
                            if (t_q == T_LAST) begin
                                state_q      <= S_IDLE;
                                t_q          <= '0;
                                load_ready_q <= 1'b1;
                                w_valid_q    <= 1'b0;
                                done_q       <= 1'b1;
                            end else begin
                                t_q <= t_q + 6'd1;
                            end
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        load_ready_q <= 1'b1;
                        w_valid_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load_ready = load_ready_q;
    assign w_valid    = w_valid_q;
    assign w_data     = win_q[0];
    assign w_index    = t_q;
    assign done       = done_q;

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(load_ready_q && w_valid_q));

    a_stall_hold: assert property (@(posedge clk) disable iff (rst || abort_act)
        (w_valid_q && !w_ready) |=> (w_valid_q && $stable(win_q[0]) && $stable(t_q)));

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: abc block, backpressure, back-to-back loads, reset, ROUNDS=16, abort.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_index;
    logic        done;
`ifdef SHA256_SCHED_ABORT_EN
    logic        abort;
`endif

    logic        lv2, lr2, wv2, wr2, dn2;
    logic [31:0] lw2, wd2;
    logic [5:0]  wi2;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] blk  [16];
    logic [31:0] expw [64];
    logic [31:0] got  [64];

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SHA256_SCHED_ABORT_EN
        .abort      (abort),
`endif
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_word  (load_word),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_index    (w_index),
        .done       (done)
    );

    sha256_msg_schedule #(.ROUNDS(16)) u_r16 (
        .clk        (clk),
        .rst        (rst),
`ifdef SHA256_SCHED_ABORT_EN
        .abort      (1'b0),
`endif
        .load_valid (lv2),
        .load_ready (lr2),
        .load_word  (lw2),
        .w_valid    (wv2),
        .w_ready    (wr2),
        .w_data     (wd2),
        .w_index    (wi2),
        .done       (dn2)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_exp();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) expw[t] = blk[t];
            else        expw[t] = ms1(expw[t-2]) + expw[t-7] + ms0(expw[t-15]) + expw[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Entered and left on a falling edge; each word is handshaken at the following rising edge
    task automatic load_block(input int first, input bit gaps);
        for (int i = first; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    load_valid = 1'b0;
                    @(negedge clk);
                end
            end
            load_valid = 1'b1;
            load_word  = blk[i];
            vectors++;
            if (load_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL load_ready word %0d: got %b expected 1", i, load_ready);
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic consume(input bit bp, input bit junk, input int stop_at, input bit preload);
        int          t = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] hd = '0;
        logic [5:0]  hi = '0;
        while (t < ROUNDS) begin
            cyc++;
            if (cyc > 2000) begin
                vectors++;
                miscompares++;
                $display("FAIL emit timeout: t=%0d got w_valid=%b expected progress", t, w_valid);
                return;
            end
            vectors++;
            if (w_valid !== 1'b1 || load_ready !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL emit ctl t=%0d: got valid=%b ready=%b done=%b expected 1 0 0",
                         t, w_valid, load_ready, done);
            end
            vectors++;
            if (w_data !== expw[t] || w_index !== 6'(t)) begin
                miscompares++;
                $display("FAIL emit word t=%0d: got %08h idx %0d expected %08h idx %0d",
                         t, w_data, w_index, expw[t], t);
            end
            if (stalled) begin
                vectors++;
                if (w_data !== hd || w_index !== hi) begin
                    miscompares++;
                    $display("FAIL stall hold: got %08h idx %0d expected %08h idx %0d",
                             w_data, w_index, hd, hi);
                end
            end
            if (t == stop_at) return;
            w_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            load_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            load_word  = $urandom;
            stalled    = !w_ready;
            hd         = w_data;
            hi         = w_index;
            if (w_ready) begin
                got[t] = w_data;
                t++;
            end
            @(negedge clk);
        end
        w_ready    = 1'b0;
        load_valid = preload;
        load_word  = blk[0];
        vectors++;
        if (done !== 1'b1 || w_valid !== 1'b0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL done cycle: got done=%b valid=%b ready=%b expected 1 0 1",
                     done, w_valid, load_ready);
        end
        @(negedge clk);
        if (!preload) begin
            vectors++;
            if (done !== 1'b0 || w_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL done width: got done=%b valid=%b expected 0 0", done, w_valid);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (load_ready !== 1'b1 || w_valid !== 1'b0 || w_data !== 32'h0 ||
            w_index !== 6'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset state: got ready=%b valid=%b data=%08h idx=%0d done=%b expected 1 0 0 0 0",
                     load_ready, w_valid, w_data, w_index, done);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (load_ready !== 1'b1 || w_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL post reset idle: got ready=%b valid=%b done=%b expected 1 0 0",
                     load_ready, w_valid, done);
        end
    endtask

    task automatic test_abc();
        set_abc();
        compute_exp();
        load_block(0, 1'b0);
        consume(1'b0, 1'b0, -1, 1'b0);
        vectors++;
        if (got[0] !== 32'h61626380 || got[15] !== 32'h00000018) begin
            miscompares++;
            $display("FAIL abc echo: got W0=%08h W15=%08h expected 61626380 00000018", got[0], got[15]);
        end
        vectors++;
        if (got[16] !== 32'h61626380) begin
            miscompares++;
            $display("FAIL abc W16: got %08h expected 61626380", got[16]);
        end
        vectors++;
        if (got[17] !== 32'h000F0000) begin
            miscompares++;
            $display("FAIL abc W17: got %08h expected 000f0000", got[17]);
        end
        vectors++;
        if (got[18] !== 32'h7DA86405) begin
            miscompares++;
            $display("FAIL abc W18: got %08h expected 7da86405", got[18]);
        end
    endtask

    task automatic test_backpressure();
        set_abc();
        compute_exp();
        load_block(0, 1'b0);
        consume(1'b1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_random();
        compute_exp();
        load_block(0, 1'b1);
        set_random();
        consume(1'b0, 1'b1, -1, 1'b1);
        compute_exp();
        load_block(1, 1'b1);
        consume(1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_emit();
        set_random();
        compute_exp();
        load_block(0, 1'b0);
        consume(1'b0, 1'b0, 30, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (w_valid !== 1'b0 || load_ready !== 1'b1 || w_index !== 6'd0) begin
            miscompares++;
            $display("FAIL async reset: got valid=%b ready=%b idx=%0d expected 0 1 0",
                     w_valid, load_ready, w_index);
        end
        @(negedge clk);
        rst     = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        set_random();
        compute_exp();
        load_block(0, 1'b0);
        consume(1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_rounds16();
        set_random();
        for (int i = 0; i < 16; i++) begin
            lv2 = 1'b1;
            lw2 = blk[i];
            @(negedge clk);
        end
        lv2 = 1'b0;
        wr2 = 1'b1;
        for (int t = 0; t < 16; t++) begin
            vectors++;
            if (wv2 !== 1'b1 || wd2 !== blk[t] || wi2 !== 6'(t)) begin
                miscompares++;
                $display("FAIL r16 word t=%0d: got valid=%b %08h idx %0d expected 1 %08h idx %0d",
                         t, wv2, wd2, wi2, blk[t], t);
            end
            @(negedge clk);
        end
        wr2 = 1'b0;
        vectors++;
        if (dn2 !== 1'b1 || wv2 !== 1'b0 || lr2 !== 1'b1) begin
            miscompares++;
            $display("FAIL r16 done: got done=%b valid=%b ready=%b expected 1 0 1", dn2, wv2, lr2);
        end
        @(negedge clk);
        vectors++;
        if (dn2 !== 1'b0 || wv2 !== 1'b0) begin
            miscompares++;
            $display("FAIL r16 after done: got done=%b valid=%b expected 0 0", dn2, wv2);
        end
    endtask

`ifdef SHA256_SCHED_ABORT_EN
    task automatic test_abort();
        set_abc();
        compute_exp();
        load_block(0, 1'b0);
        consume(1'b0, 1'b0, 5, 1'b0);
        abort   = 1'b1;
        w_ready = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        w_ready = 1'b0;
        vectors++;
        if (w_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0 || w_index !== 6'd0) begin
            miscompares++;
            $display("FAIL abort idle: got valid=%b ready=%b done=%b idx=%0d expected 0 1 0 0",
                     w_valid, load_ready, done, w_index);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort done: got %b expected 0", done);
        end
        set_random();
        compute_exp();
        load_block(0, 1'b1);
        consume(1'b0, 1'b0, -1, 1'b0);
    endtask
`endif

    initial begin
        void'($urandom(32'd12345));
        rst        = 1'b1;
        load_valid = 1'b0;
        load_word  = '0;
        w_ready    = 1'b0;
        lv2        = 1'b0;
        lw2        = '0;
        wr2        = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_emit();
        test_rounds16();
`ifdef SHA256_SCHED_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
